// File: rtl/uart_line_ctrl_pkg.sv
// Shared constants, FSM encoding and width helper for the line controller.
package uart_line_ctrl_pkg;

  localparam logic [7:0] CH_BS  = 8'h08;
  localparam logic [7:0] CH_DEL = 8'h7F;
  localparam logic [7:0] CH_CR  = 8'h0D;
  localparam logic [7:0] CH_LF  = 8'h0A;
  localparam logic [7:0] CH_SP  = 8'h20;
  localparam logic [7:0] CH_BEL = 8'h07;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DECODE = 3'd1,
    ST_SEND   = 3'd2,
    ST_GAP    = 3'd3,
    ST_COMMIT = 3'd4,
    ST_HOLD   = 3'd5
  } line_state_t;

  // Bits needed to index 'value' distinct items (minimum 1).
  function automatic int clog2(input int value);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/uart_line_store.sv
// Line buffer: synchronous write, combinational read. Contents are not reset.
module uart_line_store
  import uart_line_ctrl_pkg::*;
#(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  logic [7:0] mem [DEPTH];

  // Write the accepted character at the current line position.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Addresses past the end (non power-of-two depth) read as zero.
  always_comb begin
    rd_data = 8'h00;
    if ({1'b0, rd_addr} < DEPTH_L) rd_data = mem[rd_addr];
  end

endmodule

// File: rtl/uart_line_ctrl.sv
// Terminal line controller: pops RX bytes, applies line editing, echoes to
// the UART TX and hands completed lines to the consumer via valid/ack.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// ST_IDLE   | wait for an RX byte (only while no line is pending)
// ST_DECODE | classify the byte, update the line, load the echo sequence
// ST_SEND   | present the next sequence byte once TX is ready
// ST_GAP    | one idle cycle so TX can drop tx_ready
// ST_COMMIT | publish line_len and raise line_valid
// ST_HOLD   | line pending until line_ack
module uart_line_ctrl
  import uart_line_ctrl_pkg::*;
#(
  parameter int LINE_MAX = 32,
  parameter int ECHO     = 1,
  parameter int LEN_W    = clog2(LINE_MAX + 1),
  parameter int ADDR_W   = clog2(LINE_MAX)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [7:0]        rx_data,
  input  logic              rx_empty,
  output logic              rx_get,
  input  logic              tx_ready,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  output logic              line_valid,
  output logic [LEN_W-1:0]  line_len,
  input  logic              line_ack,
  input  logic [ADDR_W-1:0] line_raddr,
  output logic [7:0]        line_rdata
);

  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(LINE_MAX);

  line_state_t      state;
  logic [7:0]       ch;
  logic [LEN_W-1:0] count;
  logic [2:0][7:0]  seq;
  logic [1:0]       seq_len;
  logic [1:0]       seq_idx;
  logic             commit;

  logic             is_print;
  logic             is_bs;
  logic             is_cr;
  logic             has_room;
  logic [2:0][7:0]  dec_seq;
  logic [1:0]       dec_len;
  logic             dec_commit;
  logic             wr_en;

  // Character classification of the latched byte.
  always_comb begin
    is_print = (ch >= 8'h20) && (ch <= 8'h7E);
    is_bs    = (ch == CH_BS) || (ch == CH_DEL);
    is_cr    = (ch == CH_CR);
    has_room = (count < LEN_MAX);
  end

  // Echo/edit sequence that the decoded byte produces.
  always_comb begin
    dec_seq    = '0;
    dec_len    = 2'd0;
    dec_commit = 1'b0;
    if (is_print) begin
      if (!has_room) begin
        dec_seq[0] = CH_BEL;
        dec_len    = 2'd1;
      end else if (ECHO != 0) begin
        dec_seq[0] = ch;
        dec_len    = 2'd1;
      end
    end else if (is_bs) begin
      if ((count != '0) && (ECHO != 0)) begin
        dec_seq = {CH_BS, CH_SP, CH_BS};
        dec_len = 2'd3;
      end
    end else if (is_cr) begin
      dec_seq[0] = CH_CR;
      dec_seq[1] = CH_LF;
      dec_len    = 2'd2;
      dec_commit = 1'b1;
    end
  end

  assign wr_en = (state == ST_DECODE) && is_print && has_room;

  // Strobes are decoded from state so a byte pops in the cycle it is seen and
  // the first echo leaves two cycles after rx_empty falls. rx_get is gated by
  // resetn so it stays low while reset is held, even with RX data waiting.
  assign rx_get   = resetn && (state == ST_IDLE) && !rx_empty && !line_valid;
  assign tx_start = (state == ST_SEND) && tx_ready;
  assign tx_data  = (state == ST_SEND) ? seq[seq_idx] : 8'h00;

  // Line sequencing FSM.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= ST_IDLE;
      ch         <= 8'h00;
      count      <= '0;
      seq        <= '0;
      seq_len    <= 2'd0;
      seq_idx    <= 2'd0;
      commit     <= 1'b0;
      line_valid <= 1'b0;
      line_len   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!rx_empty && !line_valid) begin
            ch    <= rx_data;
            state <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          seq     <= dec_seq;
          seq_len <= dec_len;
          seq_idx <= 2'd0;
          commit  <= dec_commit;
          if (is_print) begin
            if (has_room) count <= count + LEN_W'(1);
          end else if (is_bs && (count != '0)) begin
            count <= count - LEN_W'(1);
          end
          if (dec_len != 2'd0) state <= ST_SEND;
          else if (dec_commit) state <= ST_COMMIT;
          else                 state <= ST_IDLE;
        end
        ST_SEND: begin
          if (tx_ready) begin
            seq_idx <= seq_idx + 2'd1;
            state   <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (seq_idx < seq_len) begin
            state <= ST_SEND;
          end else begin
            seq_idx <= 2'd0;
            state   <= commit ? ST_COMMIT : ST_IDLE;
          end
        end
        ST_COMMIT: begin
          line_len   <= count;
          line_valid <= 1'b1;
          commit     <= 1'b0;
          state      <= ST_HOLD;
        end
        ST_HOLD: begin
          if (line_ack) begin
            line_valid <= 1'b0;
            count      <= '0;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  uart_line_store #(
    .DEPTH  (LINE_MAX),
    .ADDR_W (ADDR_W)
  ) u_store (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (count[ADDR_W-1:0]),
    .wr_data (ch),
    .rd_addr (line_raddr),
    .rd_data (line_rdata)
  );

endmodule

// File: tb/tb_uart_line_ctrl.sv
// Bench for uart_line_ctrl: RX FIFO and TX models, line consumer, and a
// queue-based reference of the line-editing rules.
module tb_uart_line_ctrl;

  localparam int LM = 6;
  localparam int AW = $clog2(LM);
  localparam int LW = $clog2(LM + 1);

  logic          clk;
  logic          resetn;
  logic [7:0]    rx_data;
  logic          rx_empty;
  logic          rx_get;
  logic          tx_ready;
  logic          tx_start;
  logic [7:0]    tx_data;
  logic          line_valid;
  logic [LW-1:0] line_len;
  logic          line_ack;
  logic [AW-1:0] line_raddr;
  logic [7:0]    line_rdata;

  uart_line_ctrl #(.LINE_MAX(LM), .ECHO(1)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .rx_data    (rx_data),
    .rx_empty   (rx_empty),
    .rx_get     (rx_get),
    .tx_ready   (tx_ready),
    .tx_start   (tx_start),
    .tx_data    (tx_data),
    .line_valid (line_valid),
    .line_len   (line_len),
    .line_ack   (line_ack),
    .line_raddr (line_raddr),
    .line_rdata (line_rdata)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] srcq[$];
  logic [7:0] rxq[$];
  logic [7:0] exptx[$];
  logic [7:0] mline[$];
  int         expl_len[$];
  logic [7:0] expl_data[$];

  int cyc = 0;
  int pops = 0;
  int tx_cnt = 0;
  int last_tx = -1;
  int last_push_cyc = 0;
  int pend_pop = 0;
  int tx_mode = 1;      // 0 never ready, 1 always ready, 2 random
  int feed_always = 1;
  int ack_min = 0;
  int ack_span = 3;
  int stray_ack = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: line editing described as operations on a character queue.
  task automatic model_byte(input logic [7:0] b);
    if (b >= 8'h20 && b <= 8'h7E) begin
      if (mline.size() < LM) begin
        mline.push_back(b);
        exptx.push_back(b);
      end else begin
        exptx.push_back(8'h07);
      end
    end else if (b == 8'h08 || b == 8'h7F) begin
      if (mline.size() > 0) begin
        void'(mline.pop_back());
        exptx.push_back(8'h08);
        exptx.push_back(8'h20);
        exptx.push_back(8'h08);
      end
    end else if (b == 8'h0D) begin
      exptx.push_back(8'h0D);
      exptx.push_back(8'h0A);
      expl_len.push_back(mline.size());
      foreach (mline[i]) expl_data.push_back(mline[i]);
      mline.delete();
    end
  endtask

  task automatic feed(input logic [7:0] b);
    model_byte(b);
    srcq.push_back(b);
  endtask

  task automatic feed_str(input string s);
    for (int i = 0; i < s.len(); i++) feed(s[i]);
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int quiet = 0;
    int n = 0;
    while (quiet < 4 && n < budget) begin
      @(negedge clk);
      n++;
      if (srcq.size() == 0 && rxq.size() == 0 && exptx.size() == 0 &&
          expl_len.size() == 0 && !line_valid && !line_ack) quiet++;
      else quiet = 0;
    end
    chk(tag, int'(quiet >= 4), 1);
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // RX FIFO and TX-ready model, updated just after each rising edge.
  always @(posedge clk) begin
    cyc++;
    #1;
    if (pend_pop != 0) begin
      if (rxq.size() > 0) void'(rxq.pop_front());
      pops++;
    end
    if (srcq.size() > 0 && (feed_always != 0 || $urandom_range(0, 2) == 0)) begin
      if (rxq.size() == 0) last_push_cyc = cyc;
      rxq.push_back(srcq.pop_front());
    end
    tx_ready = (tx_mode == 1) || (tx_mode == 2 && $urandom_range(0, 9) < 7);
    rx_empty = (rxq.size() == 0);
    rx_data  = rx_empty ? 8'h00 : rxq[0];
  end

  // Handshake rules and echo stream, sampled mid-cycle.
  always @(negedge clk) begin
    int e;
    pend_pop = int'(rx_get);
    if (resetn) begin
      chk("rx_get_when_empty", int'(rx_get & rx_empty), 0);
      chk("rx_get_while_pending", int'(rx_get & line_valid), 0);
      chk("tx_start_not_ready", int'(tx_start & ~tx_ready), 0);
      if (tx_start) begin
        e = (exptx.size() > 0) ? int'(exptx.pop_front()) : -1;
        chk("tx_data", int'(tx_data), e);
        tx_cnt++;
        last_tx = int'(tx_data);
      end
    end
  end

  // Line consumer: checks length and contents, then acknowledges.
  initial begin
    int el;
    int eb;
    line_ack   = 1'b0;
    line_raddr = '0;
    forever begin
      @(negedge clk);
      if (line_valid && resetn) begin
        el = (expl_len.size() > 0) ? expl_len.pop_front() : -1;
        chk("line_len", int'(line_len), el);
        for (int i = 0; i < el; i++) begin
          eb = (expl_data.size() > 0) ? int'(expl_data.pop_front()) : -1;
          line_raddr = AW'(i);
          @(negedge clk);
          chk("line_data", int'(line_rdata), eb);
        end
        repeat (ack_min + $urandom_range(0, ack_span)) @(negedge clk);
        chk("line_len_stable", int'(line_len), el);
        line_ack = 1'b1;
        @(negedge clk);
        line_ack = 1'b0;
        chk("ack_clears_valid", int'(line_valid), 0);
      end else if (stray_ack != 0 && $urandom_range(0, 15) == 0) begin
        line_ack = 1'b1;
        @(negedge clk);
        line_ack = 1'b0;
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, t0, n, seen, lat;
    logic [7:0] b;
    int r;
    resetn   = 1'b0;
    rx_empty = 1'b1;
    rx_data  = 8'h00;
    tx_ready = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    chk("rst_rx_get", int'(rx_get), 0);
    chk("rst_tx_start", int'(tx_start), 0);
    chk("rst_tx_data", int'(tx_data), 0);
    chk("rst_line_valid", int'(line_valid), 0);
    chk("rst_line_len", int'(line_len), 0);
    resetn = 1'b1;

    // Directed editing cases.
    feed_str("ab"); feed(8'h0D);
    wait_idle(500, "idle_ab");
    feed_str("abc"); feed(8'h7F); feed(8'h0D);
    wait_idle(500, "idle_del");
    feed(8'h08); feed(8'h0D);
    wait_idle(500, "idle_empty_bs");
    feed_str("abcdefgh"); feed(8'h0D);
    wait_idle(800, "idle_overflow");
    feed(8'h0D);
    feed(8'h0A);
    feed(8'h01);
    wait_idle(500, "idle_misc");

    // TX stalled: one pop only, no transmit; release sends 'x' once.
    tx_mode = 0;
    p0 = pops;
    t0 = tx_cnt;
    feed_str("xy");
    repeat (20) @(negedge clk);
    chk("stall_tx_count", tx_cnt - t0, 0);
    chk("stall_pops", pops - p0, 1);
    tx_mode = 1;
    repeat (3) @(negedge clk);
    chk("release_tx_count", tx_cnt - t0, 1);
    chk("release_tx_byte", last_tx, 8'h78);
    feed(8'h0D);
    wait_idle(500, "idle_stall");

    // Pending line blocks RX pops until acknowledged.
    ack_min = 25;
    feed_str("hi"); feed(8'h0D);
    n = 0;
    while (!line_valid && n < 100) begin @(negedge clk); n++; end
    chk("pend_valid_seen", int'(line_valid), 1);
    p0 = pops;
    feed_str("123");
    n = 0;
    while (line_valid && n < 200) begin @(negedge clk); n++; end
    chk("pend_no_pops", pops - p0, 0);
    ack_min = 0;
    wait_idle(500, "idle_pend");

    // First echo two cycles after rx_empty falls.
    feed_always = 1;
    feed_str("q");
    n = 0;
    seen = 0;
    lat = -1;
    while (seen == 0 && n < 20) begin
      @(negedge clk);
      n++;
      if (tx_start) begin seen = 1; lat = cyc - last_push_cyc; end
    end
    chk("echo_latency", lat, 2);
    wait_idle(500, "idle_latency");

    // Asynchronous reset in the middle of an echo.
    tx_mode = 0;
    feed_str("ab");
    repeat (6) @(negedge clk);
    @(posedge clk);
    #3;
    resetn = 1'b0;
    #1;
    chk("async_rx_get", int'(rx_get), 0);
    chk("async_tx_start", int'(tx_start), 0);
    chk("async_tx_data", int'(tx_data), 0);
    chk("async_line_valid", int'(line_valid), 0);
    chk("async_line_len", int'(line_len), 0);
    srcq.delete(); rxq.delete(); exptx.delete(); mline.delete();
    expl_len.delete(); expl_data.delete();
    rx_empty = 1'b1;
    rx_data  = 8'h00;
    repeat (2) @(posedge clk);
    #3;
    resetn = 1'b1;
    tx_mode = 1;
    t0 = tx_cnt;
    repeat (8) @(negedge clk);
    chk("post_reset_no_tx", tx_cnt - t0, 0);
    feed_str("z"); feed(8'h0D);
    wait_idle(500, "idle_post_reset");

    // Randomized traffic.
    tx_mode = 2;
    feed_always = 0;
    stray_ack = 1;
    ack_span = 8;
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 99);
      if (r < 60)      b = 8'($urandom_range(32, 126));
      else if (r < 72) b = 8'h08;
      else if (r < 78) b = 8'h7F;
      else if (r < 90) b = 8'h0D;
      else             b = 8'($urandom_range(0, 255));
      feed(b);
      if ($urandom_range(0, 7) == 0) repeat ($urandom_range(1, 20)) @(negedge clk);
    end
    feed(8'h0D);
    wait_idle(30000, "idle_random");
    stray_ack = 0;
    repeat (4) @(negedge clk);
    chk("exp_tx_left", exptx.size(), 0);
    chk("exp_lines_left", expl_len.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_line_ctrl.md
Name: uart_line_ctrl

Overview:
Controller that sequences the receive ring buffer. It drains bytes through the buffer's get/empty handshake, assembles an editable line, and echoes keystrokes to a UART transmitter. It applies line-editing rules for backspace, carriage return and overflow, then hands each completed line to downstream logic through a valid/ack handshake. It sits between the RX ring buffer, the UART TX and the user command logic in the terminal-echo design.

Parameters:
LINE_MAX, 32, maximum characters stored per line (≥2).
ECHO, 1, 1 = echo accepted characters and edit sequences; 0 = silent (CR/LF and BEL still emitted).

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous active-low reset
rx_data  in  8  head byte of RX buffer (combinational, valid when rx_empty=0)
rx_empty  in  1  RX buffer empty
rx_get  out  1  one-cycle pop strobe to RX buffer
tx_ready  in  1  UART TX idle and able to accept a byte
tx_start  out  1  one-cycle strobe; TX latches tx_data on this cycle
tx_data  out  8  byte to transmit
line_valid  out  1  completed line available; held until line_ack
line_len  out  W  character count of the completed line; W = clog2(LINE_MAX+1)
line_ack  in  1  consumer done with line; frees the line buffer
line_raddr  in  clog2(LINE_MAX)  read address into line buffer
line_rdata  out  8  combinational read of the line buffer at line_raddr

Behaviour:
- Clock and reset: one clock domain (clk); reset is asynchronous and active-low (resetn).
- Reset values: rx_get=0, tx_start=0, tx_data=0, line_valid=0, line_len=0; state=IDLE; internal count=0, seq_idx=0, seq_len=0. Line buffer contents are undefined after reset.
- FSM states: IDLE, DECODE, SEND, GAP, COMMIT, HOLD.
- IDLE:
  - If rx_empty=0 and line_valid=0: latch ch<=rx_data, pulse rx_get for exactly this cycle, then go to DECODE.
  - Otherwise stay in IDLE. While a line is pending, the block does not pop bytes; the RX buffer absorbs them.
- DECODE (one cycle) loads a sequence queue of 0-3 bytes:
  - Printable (0x20-0x7E), count<LINE_MAX: buf[count]<=ch, count++. Queue {ch} if ECHO, else empty.
  - Printable, count==LINE_MAX: character dropped, count unchanged. Queue {0x07}.
  - 0x08 or 0x7F, count>0: count--. Queue {0x08,0x20,0x08} if ECHO, else empty.
  - 0x08 or 0x7F, count==0: no-op. Queue empty.
  - 0x0D: queue {0x0D,0x0A}; set the commit flag.
  - All other bytes (including 0x0A): ignored. Queue empty.
  - Next state: SEND if seq_len>0; else COMMIT if the commit flag is set; else IDLE.
- SEND: when tx_ready=1, drive tx_data=seq[seq_idx] with tx_start=1 for one cycle, seq_idx++, then go to GAP. While tx_ready=0, wait in SEND with tx_start=0.
- GAP: one idle cycle so TX can drop tx_ready. Then return to SEND if seq_idx<seq_len; else COMMIT if the commit flag is set; else IDLE. seq_idx is cleared on leaving the sequence.
- COMMIT (one cycle): line_len<=count, line_valid<=1, clear the commit flag, go to HOLD.
- HOLD:
  - When line_ack=1: line_valid<=0, count<=0, go to IDLE.
  - line_len and the buffer are stable throughout HOLD.
  - An empty line (CR with count 0) still commits, with line_len=0.
- Latency: from rx_empty falling to first tx_start is 2 cycles when tx_ready=1. Each additional sequence byte adds at least 2 cycles (SEND+GAP).
- line_ack outside HOLD is ignored.
- resetn assertion mid-sequence aborts immediately: no partial tx_start after release, and any pending line is discarded.
- rx_get is never asserted while rx_empty=1.
- rx_get is asserted at most once per decoded byte.

Decomposition:
- Shared package/include: character constants CH_BS=0x08, CH_DEL=0x7F, CH_CR=0x0D, CH_LF=0x0A, CH_SP=0x20, CH_BEL=0x07; FSM state encodings; clog2 helper function.
- One natural sub-module: uart_line_store. It holds the LINE_MAX×8 line buffer with a synchronous write port and a combinational read port on line_raddr.

Test Plan:
- Feed "ab" then 0x0D with tx_ready=1 → tx bytes 0x61,0x62,0x0D,0x0A. Then line_valid=1, line_len=2, rdata[0]=0x61, rdata[1]=0x62. line_ack → line_valid=0 next cycle.
- Feed "abc", 0x7F, 0x0D → tx 61,62,63,08,20,08,0D,0A; line_len=2.
- Feed 0x08 on an empty line, then 0x0D → no tx for the backspace; tx 0D,0A; line_len=0.
- LINE_MAX=4: feed "abcdef", 0x0D → echo 61-64, then 07,07,0D,0A; line_len=4; buffer holds "abcd".
- Hold tx_ready=0 for 20 cycles with 'x' queued → tx_start stays 0 and no second rx_get occurs. On release, exactly one tx_start with 0x78.
- With a line pending (no ack), push 3 bytes into RX → rx_get stays 0. After line_ack, the 3 bytes are popped in order. A separate check: assert resetn=0 mid-sequence → all outputs return to reset values asynchronously.
